rggen_host_if_apb: RTL and testbench

APB3/APB4 host interface for the register block. It converts each APB access into one command on the internal register command bus. That bus carries command_valid, address, write, write_data and write_mask, and is consumed by the address decoders and bit-field instances. The block waits for the register-side response, then completes the APB transfer. A configurable timeout terminates the access if the register side never responds.

---
 rtl/rggen_host_if_apb.sv | 135 +++++++++++++
 tb/tb_rggen_host_if_apb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rggen_host_if_apb.sv
// APB3/APB4 host interface: turns each APB access into a single command on the
// register command bus, waits for the register-side response, then completes the transfer.
module rggen_host_if_apb #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic                      i_pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic [DATA_WIDTH-1:0]     i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
  output logic                      o_pready,
  output logic [DATA_WIDTH-1:0]     o_prdata,
  output logic                      o_pslverr,
  output logic                      o_command_valid,
  output logic [ADDRESS_WIDTH-1:0]  o_address,
  output logic                      o_write,
  output logic [DATA_WIDTH-1:0]     o_write_data,
  output logic [DATA_WIDTH-1:0]     o_write_mask,
  input  logic                      i_response_ready,
  input  logic [DATA_WIDTH-1:0]     i_read_data,
  input  logic [1:0]                i_status
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   error_q;
  logic                   start;
  logic                   timeout;
  logic                   response_error;
  logic [DATA_WIDTH-1:0]  strb_mask;

  assign start          = i_psel & i_penable;
  assign timeout        = (TIMEOUT_CYCLES != 0) && (count_q == CNT_LAST);
  // status 01 is reserved and completes as OK
  assign response_error = (i_status == 2'b10) || (i_status == 2'b11);

  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      strb_mask[8*i+:8] = {8{i_pstrb[i]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    o_command_valid = 1'b0;
    o_pready        = 1'b0;
    o_pslverr       = 1'b0;
    o_prdata        = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        o_command_valid = 1'b1;
        if (i_response_ready || timeout) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_pready  = 1'b1;
        o_pslverr = error_q;
        if (!o_write && !error_q) begin
          o_prdata = rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command fields are captured once on acceptance and held through BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_address    <= '0;
      o_write      <= 1'b0;
      o_write_data <= '0;
      o_write_mask <= '0;
    end else if (state_q == IDLE && start) begin
      o_address    <= i_paddr;
      o_write      <= i_pwrite;
      o_write_data <= i_pwdata;
      o_write_mask <= i_pwrite ? strb_mask : '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      count_q <= '0;
    end else if (state_q == BUSY) begin
      if (i_response_ready) begin
        rdata_q <= i_read_data;
        error_q <= response_error;
      end else if (timeout) begin
        rdata_q <= '0;
        error_q <= 1'b1;
      end else begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_rggen_host_if_apb.sv
// Scoreboard bench for rggen_host_if_apb with a 4-cycle timeout: expected completions
// are queued when each access is driven and compared when pready pulses.
module tb_rggen_host_if_apb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_psel = 1'b0;
  logic        i_penable = 1'b0;
  logic        i_pwrite = 1'b0;
  logic [15:0] i_paddr = '0;
  logic [31:0] i_pwdata = '0;
  logic [3:0]  i_pstrb = '0;
  logic        o_pready;
  logic [31:0] o_prdata;
  logic        o_pslverr;
  logic        o_command_valid;
  logic [15:0] o_address;
  logic        o_write;
  logic [31:0] o_write_data;
  logic [31:0] o_write_mask;
  logic        i_response_ready = 1'b0;
  logic [31:0] i_read_data = '0;
  logic [1:0]  i_status = '0;

  typedef struct packed {
    logic [31:0] prdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  rggen_host_if_apb #(
    .ADDRESS_WIDTH  (16),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_psel           (i_psel),
    .i_penable        (i_penable),
    .i_pwrite         (i_pwrite),
    .i_paddr          (i_paddr),
    .i_pwdata         (i_pwdata),
    .i_pstrb          (i_pstrb),
    .o_pready         (o_pready),
    .o_prdata         (o_prdata),
    .o_pslverr        (o_pslverr),
    .o_command_valid  (o_command_valid),
    .o_address        (o_address),
    .o_write          (o_write),
    .o_write_data     (o_write_data),
    .o_write_mask     (o_write_mask),
    .i_response_ready (i_response_ready),
    .i_read_data      (i_read_data),
    .i_status         (i_status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Completion monitor: sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n && o_pready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_pready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("prdata", {32'd0, o_prdata}, {32'd0, e.prdata});
        check_eq("pslverr", {63'd0, o_pslverr}, {63'd0, e.err});
      end
    end
  end

  task automatic apb_setup_access(input logic wr, input logic [15:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] strb);
    @(posedge clk); #1;
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr;
    i_paddr = addr; i_pwdata = wdata; i_pstrb = strb;
    @(posedge clk); #1;
    i_penable = 1'b1;
  endtask

  // delay < 0 means the register side never responds.
  task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int delay, input logic [31:0] rdata,
                          input logic [1:0] status, input bit drop,
                          input logic [31:0] exp_mask, input int exp_busy,
                          input logic [31:0] exp_prdata, input logic exp_err);
    int busy = 0;
    apb_setup_access(wr, addr, wdata, strb);
    sb_q.push_back('{prdata: exp_prdata, err: exp_err});
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (o_pready) break;
      check_eq("command_valid", {63'd0, o_command_valid}, 64'd1);
      check_eq("address", {48'd0, o_address}, {48'd0, addr});
      check_eq("write_data", {32'd0, o_write_data}, {32'd0, wdata});
      check_eq("write_mask", {32'd0, o_write_mask}, {32'd0, exp_mask});
      if (cyc == 0) check_eq("write", {63'd0, o_write}, {63'd0, wr});
      busy++;
      i_paddr = ~addr; i_pwdata = ~wdata; i_pstrb = ~strb;
      if (drop) begin
        i_psel = 1'b0; i_penable = 1'b0;
      end
      i_response_ready = (cyc == delay);
      i_read_data = rdata;
      i_status = status;
      @(posedge clk); #1;
      i_response_ready = 1'b0;
      i_read_data = 32'h5555_AAAA;
      i_status = 2'b11;
    end
    check_eq("pready_seen", {63'd0, o_pready}, 64'd1);
    check_eq("busy_cycles", 64'(busy), 64'(exp_busy));
    check_eq("valid_in_done", {63'd0, o_command_valid}, 64'd0);
    i_psel = 1'b0; i_penable = 1'b0;
    @(posedge clk); #1;
    check_eq("pready_one_cycle", {63'd0, o_pready}, 64'd0);
    check_eq("idle_valid", {63'd0, o_command_valid}, 64'd0);
  endtask

  initial begin
    #2;
    check_eq("rst_pready", {63'd0, o_pready}, 64'd0);
    check_eq("rst_valid", {63'd0, o_command_valid}, 64'd0);
    check_eq("rst_mask", {32'd0, o_write_mask}, 64'd0);
    check_eq("rst_address", {48'd0, o_address}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //        wr    addr      wdata         strb     dly rdata          st     drop mask           busy prdata         err
    apb_xfer(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF,    0, 32'hFFFF_FFFF, 2'b00, 0, 32'hFFFF_FFFF, 1, 32'h0,          1'b0);
    apb_xfer(1'b1, 16'h0014, 32'h12345678, 4'b0101, 1, 32'h0,         2'b01, 0, 32'h00FF_00FF, 2, 32'h0,          1'b0);
    apb_xfer(1'b0, 16'h0020, 32'h0,        4'h0,    3, 32'hA5A5_0001, 2'b00, 0, 32'hFFFF_FFFF, 4, 32'hA5A5_0001, 1'b0);
    apb_xfer(1'b0, 16'h0024, 32'h0,        4'h0,    0, 32'h0000_1234, 2'b11, 0, 32'hFFFF_FFFF, 1, 32'h0,          1'b1);
    apb_xfer(1'b1, 16'h0028, 32'h0BAD_F00D, 4'b1000, 2, 32'h0,        2'b10, 0, 32'hFF00_0000, 3, 32'h0,          1'b1);
    // Timeout with no response, then a response landing on the last allowed cycle.
    apb_xfer(1'b0, 16'h0030, 32'h0,        4'h0,   -1, 32'h0,         2'b00, 0, 32'hFFFF_FFFF, 4, 32'h0,          1'b1);
    apb_xfer(1'b0, 16'h0034, 32'h0,        4'h0,    3, 32'hCAFE_0003, 2'b00, 0, 32'hFFFF_FFFF, 4, 32'hCAFE_0003, 1'b0);
    // psel/penable dropped mid-BUSY: the command still completes.
    apb_xfer(1'b0, 16'h0038, 32'h0,        4'h0,    2, 32'h7777_0008, 2'b00, 1, 32'hFFFF_FFFF, 3, 32'h7777_0008, 1'b0);

    // Reset in the middle of a BUSY access.
    apb_setup_access(1'b1, 16'h0040, 32'h1111_2222, 4'hF);
    @(posedge clk); #1;
    check_eq("pre_rst_valid", {63'd0, o_command_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {63'd0, o_command_valid}, 64'd0);
    check_eq("midrst_address", {48'd0, o_address}, 64'd0);
    check_eq("midrst_data", {32'd0, o_write_data}, 64'd0);
    check_eq("midrst_mask", {32'd0, o_write_mask}, 64'd0);
    check_eq("midrst_write", {63'd0, o_write}, 64'd0);
    i_psel = 1'b0; i_penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back writes after reset.
    apb_xfer(1'b1, 16'h0044, 32'hFEED_0001, 4'b0011, 0, 32'h0,        2'b00, 0, 32'h0000_FFFF, 1, 32'h0,          1'b0);
    apb_xfer(1'b1, 16'h0048, 32'hFEED_0002, 4'b1100, 0, 32'h0,        2'b00, 0, 32'hFFFF_0000, 1, 32'h0,          1'b0);

    repeat (2) @(posedge clk);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
